// File: rtl/stopwatch_ctrl_pkg.sv
// rtl/stopwatch_ctrl_pkg.sv - shared state encoding and defaults for the stopwatch sequencer
package stopwatch_ctrl_pkg;

  localparam int STATE_W   = 3;
  localparam int LAP_W_DEF = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_LAP   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_FULL  = 3'd4
  } sw_state_e;

endpackage

// File: rtl/stopwatch_ctrl_edge_sync.sv
// rtl/stopwatch_ctrl_edge_sync.sv - N-stage synchroniser with rising-edge output
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  // Fewer than two flops would not resolve metastability, so clamp upwards.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
      prev_q <= sync_q[N-1];
    end
  end

  assign q_o    = sync_q[N-1];
  assign rise_o = sync_q[N-1] & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/lap/clear sequencer driving the stopwatch time counter
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int LAP_W       = LAP_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_100hz,
  input  logic             btn_ss,
  input  logic             btn_lap,
  input  logic             at_max,
  input  logic             blink_in,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             disp_hold,
  output logic [LAP_W-1:0] lap_cnt,
  output logic [2:0]       state,
  output logic             led_run,
  output logic             led_flash
);

  localparam logic [LAP_W-1:0] LAP_MAX = {LAP_W{1'b1}};

  sw_state_e        state_q, state_d;
  logic             btn_ss_q, btn_lap_q;
  logic [LAP_W-1:0] lap_cnt_q;
  logic             cnt_clr_q, disp_hold_q, led_run_q, led_flash_q;
  logic             clr_d, inc_d, flash_d;
  logic             ss_rise, lap_rise, lap_ev, full_ev;
  logic             blink_s, blink_rise_unused;

  edge_sync #(.STAGES(SYNC_STAGES)) u_blink_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (blink_in),
    .q_o    (blink_s),
    .rise_o (blink_rise_unused)
  );

  assign ss_rise  = btn_ss  & ~btn_ss_q;
  assign lap_rise = btn_lap & ~btn_lap_q;
  // Simultaneous presses resolve in favour of start/stop.
  assign lap_ev   = lap_rise & ~ss_rise;
  assign full_ev  = tick_100hz & at_max;

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    inc_d   = 1'b0;
    case (state_q)
      ST_IDLE:  if (ss_rise) state_d = ST_RUN;
      ST_RUN: begin
        if (ss_rise)      state_d = ST_PAUSE;
        else if (lap_ev) begin state_d = ST_LAP; inc_d = 1'b1; end
        else if (full_ev) state_d = ST_FULL;
      end
      ST_LAP: begin
        if (ss_rise)      state_d = ST_PAUSE;
        else if (lap_ev) begin state_d = ST_RUN; inc_d = 1'b1; end
        else if (full_ev) state_d = ST_FULL;
      end
      ST_PAUSE: begin
        if (ss_rise)     state_d = ST_RUN;
        else if (lap_ev) begin state_d = ST_IDLE; clr_d = 1'b1; end
      end
      ST_FULL:  if (lap_ev) begin state_d = ST_IDLE; clr_d = 1'b1; end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    flash_d = blink_s;
    case (state_d)
      ST_IDLE:        flash_d = 1'b0;
      ST_RUN, ST_LAP: flash_d = 1'b1;
      default:        flash_d = blink_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      btn_ss_q    <= 1'b1;
      btn_lap_q   <= 1'b1;
      lap_cnt_q   <= '0;
      cnt_clr_q   <= 1'b0;
      disp_hold_q <= 1'b0;
      led_run_q   <= 1'b0;
      led_flash_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_ss_q    <= btn_ss;
      btn_lap_q   <= btn_lap;
      if (clr_d)
        lap_cnt_q <= '0;
      else if (inc_d && lap_cnt_q != LAP_MAX)
        lap_cnt_q <= lap_cnt_q + 1'b1;
      cnt_clr_q   <= clr_d;
      disp_hold_q <= (state_d == ST_LAP);
      led_run_q   <= (state_d == ST_RUN) || (state_d == ST_LAP);
      led_flash_q <= flash_d;
    end
  end

  assign cnt_en    = tick_100hz & ((state_q == ST_RUN) | (state_q == ST_LAP)) & ~at_max;
  assign cnt_clr   = cnt_clr_q;
  assign disp_hold = disp_hold_q;
  assign lap_cnt   = lap_cnt_q;
  assign state     = state_q;
  assign led_run   = led_run_q;
  assign led_flash = led_flash_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed vector bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

  localparam int LAP_W = 2;

  logic             clk = 1'b0;
  logic             rst_n, tick_100hz, btn_ss, btn_lap, at_max, blink_in;
  logic             cnt_en, cnt_clr, disp_hold, led_run, led_flash;
  logic [LAP_W-1:0] lap_cnt;
  logic [2:0]       state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic       ss, lap, tick, atm;
    logic       e_en;
    logic [2:0] e_st;
    logic [1:0] e_lap;
    logic       e_hold, e_clr, e_run;
  } vec_t;

  vec_t vecs[$];

  stopwatch_ctrl #(.LAP_W(LAP_W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_100hz (tick_100hz),
    .btn_ss     (btn_ss),
    .btn_lap    (btn_lap),
    .at_max     (at_max),
    .blink_in   (blink_in),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .disp_hold  (disp_hold),
    .lap_cnt    (lap_cnt),
    .state      (state),
    .led_run    (led_run),
    .led_flash  (led_flash)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s act=%0d req=%0d at %0t", name, act, exp, $time);
  endtask

  function automatic void add(input logic ss, lap, tick, atm, en, input logic [2:0] st,
                              input logic [1:0] lp, input logic hold, clr, run);
    vec_t v;
    v.ss = ss; v.lap = lap; v.tick = tick; v.atm = atm; v.e_en = en; v.e_st = st;
    v.e_lap = lp; v.e_hold = hold; v.e_clr = clr; v.e_run = run;
    vecs.push_back(v);
  endfunction

  // Inputs change just after a posedge; cnt_en is sampled at the negedge,
  // registered outputs one unit after the following posedge.
  task automatic step(input vec_t v, input string tag);
    btn_ss = v.ss; btn_lap = v.lap; tick_100hz = v.tick; at_max = v.atm;
    @(negedge clk);
    chk({tag, ".cnt_en"}, int'(cnt_en), int'(v.e_en));
    @(posedge clk); #1;
    chk({tag, ".state"},     int'(state),     int'(v.e_st));
    chk({tag, ".lap_cnt"},   int'(lap_cnt),   int'(v.e_lap));
    chk({tag, ".disp_hold"}, int'(disp_hold), int'(v.e_hold));
    chk({tag, ".cnt_clr"},   int'(cnt_clr),   int'(v.e_clr));
    chk({tag, ".led_run"},   int'(led_run),   int'(v.e_run));
    chk({tag, ".led_flash"}, int'(led_flash), int'(v.e_run));
  endtask

  task automatic hstep(input logic ss, lap, tick, atm, en, input logic [2:0] st,
                       input logic [1:0] lp, input logic hold, clr, run, input string tag);
    vec_t v;
    v.ss = ss; v.lap = lap; v.tick = tick; v.atm = atm; v.e_en = en; v.e_st = st;
    v.e_lap = lp; v.e_hold = hold; v.e_clr = clr; v.e_run = run;
    step(v, tag);
  endtask

  initial begin
    //  ss lap tk atm  en st lap hold clr run
    add(1, 1, 0, 0,   0, 0, 0, 0, 0, 0);  // 0  buttons held through reset
    add(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0,   0, 1, 0, 0, 0, 1);  // 2  start
    add(0, 0, 1, 0,   1, 1, 0, 0, 0, 1);  // 3  tick 1
    add(0, 0, 1, 0,   1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0,   0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0,   1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0,   1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0,   1, 1, 0, 0, 0, 1);  // 8  tick 5
    add(1, 0, 1, 0,   1, 3, 0, 0, 0, 0);  // 9  stop with coincident tick
    add(0, 0, 1, 0,   0, 3, 0, 0, 0, 0);
    add(1, 0, 0, 0,   0, 1, 0, 0, 0, 1);  // 11 resume
    add(0, 1, 0, 0,   0, 2, 1, 1, 0, 1);  // 12 lap 1
    add(0, 0, 1, 0,   1, 2, 1, 1, 0, 1);
    add(0, 1, 0, 0,   0, 1, 2, 0, 0, 1);  // 14 lap 2
    add(0, 0, 0, 0,   0, 1, 2, 0, 0, 1);
    add(0, 1, 0, 0,   0, 2, 3, 1, 0, 1);  // 16 lap 3
    add(0, 0, 0, 0,   0, 2, 3, 1, 0, 1);
    add(0, 1, 0, 0,   0, 1, 3, 0, 0, 1);  // 18 lap 4 saturates
    add(0, 0, 0, 0,   0, 1, 3, 0, 0, 1);
    add(0, 1, 0, 0,   0, 2, 3, 1, 0, 1);  // 20 lap 5
    add(0, 0, 0, 0,   0, 2, 3, 1, 0, 1);
    add(1, 0, 0, 0,   0, 3, 3, 0, 0, 0);  // 22 pause from LAP
    add(0, 0, 0, 0,   0, 3, 3, 0, 0, 0);
    add(0, 1, 0, 0,   0, 0, 0, 0, 1, 0);  // 24 clear
    add(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // 25 clear pulse gone
    add(1, 0, 0, 0,   0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0,   0, 1, 0, 0, 0, 1);
    add(0, 1, 0, 0,   0, 2, 1, 1, 0, 1);
    add(0, 0, 0, 0,   0, 2, 1, 1, 0, 1);
    add(1, 0, 0, 0,   0, 3, 1, 0, 0, 0);
    add(0, 0, 0, 0,   0, 3, 1, 0, 0, 0);
    add(1, 1, 0, 0,   0, 1, 1, 0, 0, 1);  // 32 both rise from PAUSE
    add(0, 0, 0, 0,   0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 1,   0, 1, 1, 0, 0, 1);  // 34 at_max without tick
    add(0, 0, 1, 1,   0, 4, 1, 0, 0, 0);  // 35 full
    add(1, 0, 0, 1,   0, 4, 1, 0, 0, 0);  // 36 start ignored
    add(0, 0, 0, 1,   0, 4, 1, 0, 0, 0);
    add(0, 1, 0, 1,   0, 0, 0, 0, 1, 0);  // 38 clear from FULL
    add(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0,   0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0,   0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 1,   0, 3, 0, 0, 0, 0);  // 42 button beats at_max
    add(0, 0, 0, 0,   0, 3, 0, 0, 0, 0);

    rst_n = 1'b0; btn_ss = 1'b1; btn_lap = 1'b1; tick_100hz = 1'b0; at_max = 1'b0;
    blink_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state",     int'(state),     0);
    chk("rst.lap_cnt",   int'(lap_cnt),   0);
    chk("rst.cnt_en",    int'(cnt_en),    0);
    chk("rst.cnt_clr",   int'(cnt_clr),   0);
    chk("rst.disp_hold", int'(disp_hold), 0);
    chk("rst.led_run",   int'(led_run),   0);
    chk("rst.led_flash", int'(led_flash), 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i], $sformatf("v%0d", i));

    // Blink passes through the synchroniser and then the flash register.
    hstep(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, "blk.start");
    hstep(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, "blk.rel");
    btn_ss = 0; btn_lap = 0; tick_100hz = 1; at_max = 1;
    @(posedge clk); #1;
    chk("blk.full_state", int'(state), 4);
    tick_100hz = 0;
    blink_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("blk.rise_early", int'(led_flash), 0);
    @(posedge clk); #1;
    chk("blk.rise_seen", int'(led_flash), 1);
    blink_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("blk.fall_early", int'(led_flash), 1);
    @(posedge clk); #1;
    chk("blk.fall_seen", int'(led_flash), 0);
    chk("blk.cnt_en", int'(cnt_en), 0);
    blink_in = 1'b1;
    hstep(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, "blk.clear");
    blink_in = 1'b0;
    hstep(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "blk.idle");

    // Reset asserted while in LAP, with a tick present.
    hstep(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, "mrst.start");
    hstep(0, 1, 0, 0, 0, 2, 1, 1, 0, 1, "mrst.lap");
    btn_lap = 0; tick_100hz = 1; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst.state",     int'(state),     0);
    chk("mrst.lap_cnt",   int'(lap_cnt),   0);
    chk("mrst.cnt_en",    int'(cnt_en),    0);
    chk("mrst.cnt_clr",   int'(cnt_clr),   0);
    chk("mrst.disp_hold", int'(disp_hold), 0);
    chk("mrst.led_run",   int'(led_run),   0);
    chk("mrst.led_flash", int'(led_flash), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run/pause/lap/clear sequencer for the digital stopwatch. It consumes debounced button levels, a single-cycle 100 Hz tick enable and the 2 Hz flash level. It drives the time-counter datapath (count enable, clear), the display hold for lap, a lap counter and the status LEDs. It sits between the clock divider / debouncers and the BCD time counter and display scanner, and runs entirely on the system clock.

Parameters:
LAP_W, 4, width of the lap counter (saturates at 2^LAP_W-1)
SYNC_STAGES, 2, flops in the synchroniser for blink_in (minimum 2)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  synchronous, active-low reset
tick_100hz  in  1  one-clk-wide enable pulse at 100 Hz, synchronous to clk
btn_ss  in  1  debounced start/stop button level, active high
btn_lap  in  1  debounced lap/clear button level, active high
at_max  in  1  time counter is at its maximum value (59:59.99), level
blink_in  in  1  2 Hz flash level from the divider; asynchronous to clk
cnt_en  out  1  advance time counter by 0.01 s this cycle
cnt_clr  out  1  one-cycle synchronous clear of the time counter
disp_hold  out  1  display shows the frozen lap value while high
lap_cnt  out  LAP_W  number of laps taken since the last clear
state  out  3  encoded FSM state, for debug and display
led_run  out  1  run indicator
led_flash  out  1  status LED (steady or flashing)

Behaviour:
- Reset: rst_n is sampled at a clk edge while low. It forces:
  - state=IDLE, lap_cnt=0, all outputs 0.
  - Button history registers = 1, so a button held through reset produces no edge.
  - blink synchroniser = 0.
- Edge detect:
  - ss_rise = btn_ss & ~btn_ss_q; lap_rise = btn_lap & ~btn_lap_q (history registered every clk).
  - If both rise in the same cycle, ss_rise wins and lap_rise is discarded.
- States and encoding: IDLE=0, RUN=1, LAP=2, PAUSE=3, FULL=4.
- Transitions, registered and applied at the edge where the rise is seen:
  - IDLE: ss_rise -> RUN. lap_rise is ignored.
  - RUN: ss_rise -> PAUSE. lap_rise -> LAP, and lap_cnt increments. tick_100hz & at_max -> FULL.
  - LAP: lap_rise -> RUN, and lap_cnt increments. ss_rise -> PAUSE. tick_100hz & at_max -> FULL.
  - PAUSE: ss_rise -> RUN. lap_rise -> IDLE with cnt_clr=1 for exactly one cycle and lap_cnt <= 0.
  - FULL: lap_rise -> IDLE with cnt_clr pulse and lap_cnt <= 0. ss_rise is ignored.
  - Within RUN/LAP, a button event takes priority over the at_max transition in the same cycle.
- cnt_en:
  - Combinational: tick_100hz & (state==RUN | state==LAP) & ~at_max.
  - Uses the current registered state, so a tick coinciding with ss_rise in RUN is still counted.
  - cnt_en and cnt_clr are never high together.
- cnt_clr is registered: high in the cycle after the transition edge, for one cycle.
- disp_hold is registered: 1 exactly while state==LAP; it drops on entering PAUSE, RUN or FULL.
- lap_cnt saturates at 2^LAP_W-1; further laps still toggle LAP/RUN but do not wrap.
- Status LEDs, registered from the next state:
  - led_run = 1 in RUN or LAP.
  - led_flash = 0 in IDLE, 1 in RUN/LAP, and the synchronised blink in PAUSE/FULL.
- blink_in passes through SYNC_STAGES flops before use.

Decomposition:
- Shared package: state encoding constants (IDLE..FULL, width 3) and the default LAP_W. The display mux uses them too.
- Natural sub-module: edge_sync, a parameterised N-stage synchroniser with optional rising-edge output. It is used for blink_in here and reused by the debouncer.
- The FSM and lap counter stay in stopwatch_ctrl.

Test Plan:
- Reset with btn_ss held high, release rst_n -> state stays 0, no cnt_en. Release then press btn_ss -> state=1 one clk later.
- RUN, 5 tick_100hz pulses -> exactly 5 cnt_en pulses. Press btn_ss in the same cycle as a tick -> that tick counted, state=3, later ticks give cnt_en=0.
- RUN, press btn_lap -> state=2, disp_hold=1, lap_cnt=1, cnt_en still follows ticks. Press btn_lap again -> state=1, disp_hold=0, lap_cnt=2.
- With LAP_W=2, 5 laps -> lap_cnt=3 (saturated). Then btn_ss, then btn_lap -> state=0, cnt_clr high exactly 1 clk, lap_cnt=0.
- RUN with at_max=1 and a tick -> cnt_en=0, state=4, led_flash follows the synchronised blink_in (2-clk delay). btn_ss ignored; btn_lap -> IDLE with cnt_clr.
- btn_ss and btn_lap rise in the same cycle from PAUSE -> state=1, no cnt_clr, lap_cnt unchanged. Assert rst_n low mid-LAP -> all outputs 0 at the next clk.
